// File: rtl/demux_1n_stream.sv
// rtl/demux_1n_stream.sv - 1-to-N stream demultiplexer with per-channel holding registers
//
// Purpose: routes one input word stream to N output channels using a select,
// broadcast or rotate policy. Each channel has one holding register, and a channel
// can drain and reload in the same cycle.
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   e         active-low enable (1 blocks the input; drains continue)
//   mode      00 select, 01 broadcast, 10 rotate, 11 treated as select
//   s         channel select (select mode only)
//   i         input data
//   in_valid  input word present
//   in_ready  input word accepted this cycle (no path from in_valid or i)
//   y         channel k data on bits [k*WIDTH +: WIDTH]
//   y_valid   per-channel valid
//   y_ready   per-channel downstream ready
//   err       sticky flag: a select-mode word addressed a channel >= N
module demux_1n_stream #(
  parameter int WIDTH = 1,
  parameter int N     = 4,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  input  logic [1:0]       mode,
  input  logic [SW-1:0]    s,
  input  logic [WIDTH-1:0] i,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N*WIDTH-1:0] y,
  output logic [N-1:0]     y_valid,
  input  logic [N-1:0]     y_ready,
  output logic             err
);

  logic [WIDTH-1:0] data_q [N];
  logic [WIDTH-1:0] data_d [N];
  logic [N-1:0]     valid_q, valid_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic             err_q, err_d;

  logic [N-1:0]     free;
  logic [N-1:0]     load;
  logic             free_sel;
  logic             free_ptr;
  logic             sel_in_range;
  logic             ready_int;
  logic             accept;

  always_comb begin
    // A channel is free if it is empty or is being drained at this edge.
    free         = ~valid_q | y_ready;
    sel_in_range = (int'(s) < N);

    // An out-of-range select has no target, so it never stalls the input.
    free_sel = 1'b1;
    free_ptr = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (int'(s) == k) free_sel = free[k];
      if (int'(ptr_q) == k) free_ptr = free[k];
    end

    case (mode)
      2'b01:   ready_int = &free;
      2'b10:   ready_int = free_ptr;
      default: ready_int = free_sel;
    endcase

    in_ready = ~e & ready_int;
    accept   = in_valid & in_ready;

    load = '0;
    for (int k = 0; k < N; k++) begin
      case (mode)
        2'b01:   load[k] = accept;
        2'b10:   load[k] = accept & (int'(ptr_q) == k);
        default: load[k] = accept & (int'(s) == k);
      endcase
    end

    // A reload at the same edge as a drain keeps the channel valid.
    valid_d = load | (valid_q & ~y_ready);

    data_d = data_q;
    for (int k = 0; k < N; k++) begin
      if (load[k]) data_d[k] = i;
    end

    ptr_d = ptr_q;
    if (accept && (mode == 2'b10)) begin
      ptr_d = (int'(ptr_q) == N - 1) ? '0 : ptr_q + SW'(1);
    end

    err_d = err_q | (accept & (mode != 2'b01) & (mode != 2'b10) & ~sel_in_range);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign y[g*WIDTH +: WIDTH] = data_q[g];
  end

  assign y_valid = valid_q;
  assign err     = err_q;

endmodule

// File: tb/tb_demux_1n_stream.sv
// tb/tb_demux_1n_stream.sv - self-checking bench for demux_1n_stream (N=4 and N=3)
module tb_demux_1n_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // N=4, WIDTH=8 instance
  logic        e4 = 1'b1;
  logic [1:0]  mode4 = 2'b00;
  logic [1:0]  s4 = 2'd0;
  logic [7:0]  i4 = 8'h00;
  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [31:0] y4;
  logic [3:0]  y_valid4;
  logic [3:0]  y_ready4 = 4'h0;
  logic        err4;

  // N=3, WIDTH=8 instance
  logic        e3 = 1'b1;
  logic [1:0]  mode3 = 2'b00;
  logic [1:0]  s3 = 2'd0;
  logic [7:0]  i3 = 8'h00;
  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [23:0] y3;
  logic [2:0]  y_valid3;
  logic [2:0]  y_ready3 = 3'h0;
  logic        err3;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model of the N=4 instance: per-channel holding slots plus rotate pointer.
  bit         m_valid [4];
  logic [7:0] m_data  [4];
  int         m_ptr;

  always #5 clk = ~clk;

  demux_1n_stream #(.WIDTH(8), .N(4)) dut4 (
    .clk(clk), .rst(rst), .e(e4), .mode(mode4), .s(s4), .i(i4),
    .in_valid(in_valid4), .in_ready(in_ready4), .y(y4), .y_valid(y_valid4),
    .y_ready(y_ready4), .err(err4)
  );

  demux_1n_stream #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst(rst), .e(e3), .mode(mode3), .s(s3), .i(i3),
    .in_valid(in_valid3), .in_ready(in_ready3), .y(y3), .y_valid(y_valid3),
    .y_ready(y_ready3), .err(err3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    bit all_free;
    if (e4) return 1'b0;
    all_free = 1'b1;
    for (int k = 0; k < 4; k++) all_free &= (!m_valid[k] || y_ready4[k]);
    if (mode4 == 2'b01) return all_free;
    if (mode4 == 2'b10) return !m_valid[m_ptr] || y_ready4[m_ptr];
    return !m_valid[s4] || y_ready4[s4];
  endfunction

  function automatic logic [3:0] m_yv();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_valid[k];
    return v;
  endfunction

  function automatic logic [31:0] m_y();
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = m_data[k];
    return v;
  endfunction

  // One clock of the N=4 instance: check in_ready before the edge, advance the
  // model at the edge, check outputs just after it.
  task automatic step4(input string tag);
    bit rdy, acc, tgt;
    #1;
    rdy = m_ready();
    chk({tag, ".in_ready"}, 64'(in_ready4), 64'(rdy));
    acc = in_valid4 && rdy;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_valid[k] = 1'b0;
        m_data[k]  = 8'h00;
      end
      m_ptr = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (mode4 == 2'b01)      tgt = 1'b1;
        else if (mode4 == 2'b10) tgt = (m_ptr == k);
        else                     tgt = (s4 == k);
        if (acc && tgt) begin
          m_valid[k] = 1'b1;
          m_data[k]  = i4;
        end else if (y_ready4[k]) begin
          m_valid[k] = 1'b0;
        end
      end
      if (acc && mode4 == 2'b10) m_ptr = (m_ptr + 1) % 4;
    end
    #1;
    chk({tag, ".y_valid"}, 64'(y_valid4), 64'(m_yv()));
    chk({tag, ".y"}, 64'(y4), 64'(m_y()));
    chk({tag, ".err"}, 64'(err4), 64'd0);
  endtask

  task automatic reset4();
    rst = 1'b1;
    in_valid4 = 1'b0;
    step4("reset");
    rst = 1'b0;
  endtask

  task automatic step3();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = 8'h00;
    end
    m_ptr = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    reset4();
    chk("reset.y_valid_const", 64'(y_valid4), 64'd0);
    chk("reset.y_const", 64'(y4), 64'd0);

    // Blocked input: nothing accepted in any mode.
    e4 = 1'b1; in_valid4 = 1'b1; i4 = 8'hA5; y_ready4 = 4'h0;
    for (int m = 0; m < 4; m++) begin
      mode4 = 2'(m);
      #1;
      chk("blocked.in_ready_const", 64'(in_ready4), 64'd0);
      step4("blocked");
      chk("blocked.y_valid_const", 64'(y_valid4), 64'd0);
    end

    // Select mode walks s over all channels.
    e4 = 1'b0; mode4 = 2'b00; y_ready4 = 4'hF;
    for (int k = 0; k < 4; k++) begin
      s4 = 2'(k); i4 = 8'h10 + 8'(k);
      step4("select");
      chk("select.onehot", 64'(y_valid4), 64'(4'b0001 << k));
      chk("select.lane", 64'(y4[k*8 +: 8]), 64'(8'h10 + 8'(k)));
    end

    // Broadcast waits for all channels to be free.
    reset4();
    mode4 = 2'b00; s4 = 2'd0; i4 = 8'h77; in_valid4 = 1'b1; y_ready4 = 4'h0;
    step4("bc_prefill");
    mode4 = 2'b01; i4 = 8'h3C; y_ready4 = 4'b1110;
    #1;
    chk("bc.stalled_const", 64'(in_ready4), 64'd0);
    step4("bc_stall");
    y_ready4 = 4'hF;
    step4("bc_go");
    chk("bc.y_valid_const", 64'(y_valid4), 64'hF);
    chk("bc.y_const", 64'(y4), 64'h3C3C3C3C);

    // Rotate: six accepts wrap the pointer 0,1,2,3,0,1.
    reset4();
    mode4 = 2'b10; y_ready4 = 4'hF; in_valid4 = 1'b1;
    for (int n = 0; n < 6; n++) begin
      i4 = 8'(n + 1);
      step4("rotate");
      chk("rotate.target", 64'(y_valid4), 64'(4'b0001 << (n % 4)));
    end
    i4 = 8'h07;
    step4("rotate_ptr2");
    chk("rotate.ptr_is_2", 64'(y_valid4), 64'b0100);
    reset4();
    in_valid4 = 1'b1; i4 = 8'h08;
    step4("rotate_after_rst");
    chk("rotate.ptr_reset", 64'(y_valid4), 64'b0001);

    // Hold channel 2 under backpressure, then drain and reload in one edge.
    reset4();
    mode4 = 2'b00; s4 = 2'd2; i4 = 8'h5A; in_valid4 = 1'b1; y_ready4 = 4'h0;
    step4("hold_load");
    in_valid4 = 1'b0; i4 = 8'hFF;
    for (int n = 0; n < 5; n++) begin
      step4("hold");
      chk("hold.lane2_const", 64'(y4[23:16]), 64'h5A);
    end
    y_ready4 = 4'b0100; in_valid4 = 1'b1; i4 = 8'hC3;
    step4("reload");
    chk("reload.valid_const", 64'(y_valid4[2]), 64'd1);
    chk("reload.lane2_const", 64'(y4[23:16]), 64'hC3);
    in_valid4 = 1'b0;
    step4("drain");
    chk("drain.lane2_kept", 64'(y4[23:16]), 64'hC3);

    // Randomized traffic against the model, including occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom % 40) == 0;
      e4        = ($urandom % 5) == 0;
      mode4     = 2'($urandom % 4);
      s4        = 2'($urandom % 4);
      i4        = 8'($urandom);
      in_valid4 = ($urandom % 4) != 0;
      y_ready4  = 4'($urandom);
      step4("random");
    end
    rst = 1'b0;

    // N=3 out-of-range select: accepted, dropped, sticky err.
    rst = 1'b1; step3(); rst = 1'b0;
    chk("n3.err_reset", 64'(err3), 64'd0);
    e3 = 1'b0; mode3 = 2'b00; s3 = 2'd3; i3 = 8'h99; in_valid3 = 1'b1; y_ready3 = 3'b000;
    #1;
    chk("n3.in_ready_oor", 64'(in_ready3), 64'd1);
    step3();
    chk("n3.y_valid_oor", 64'(y_valid3), 64'd0);
    chk("n3.err_set", 64'(err3), 64'd1);
    s3 = 2'd1; i3 = 8'h42;
    step3();
    chk("n3.y_valid_sel1", 64'(y_valid3), 64'b010);
    chk("n3.lane1", 64'(y3[15:8]), 64'h42);
    in_valid3 = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step3();
      chk("n3.err_sticky", 64'(err3), 64'd1);
    end
    rst = 1'b1; step3(); rst = 1'b0;
    chk("n3.err_cleared", 64'(err3), 64'd0);
    chk("n3.y_valid_cleared", 64'(y_valid3), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
